psum_writer: RTL and testbench

Write-back stage between the systolic PE array's row outputs and the per-row psum memories. It accepts 32-bit partial sums from each array row and packs pairs into 64-bit psum memory words. It drives the controller-side psum write port (`psum_mem_we/addr/din`) with byte enables and signals completion of a tile to the controller. There is one independent packing lane per array row.

---
 rtl/psum_writer_pkg.sv | 19 +
 rtl/psum_pack_lane.sv | 87 ++++++++
 rtl/psum_writer.sv | 111 +++++++++++
 tb/tb_psum_writer.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/psum_writer_pkg.sv
// Shared types and constants for the psum write-back stage.
package psum_writer_pkg;

    // Width of one partial sum; two of them fill one 64-bit memory word.
    localparam int PSUM_W = 32;

    // Byte enables: lower half only (flush of a lone psum) and full word.
    localparam logic [7:0] BE_LO   = 8'h0F;
    localparam logic [7:0] BE_FULL = 8'hFF;

    // Tile sequencing states.
    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH,
        DONE
    } pw_state_t;

endpackage

// File: rtl/psum_pack_lane.sv
// One packing lane: pairs consecutive psums of a single array row into
// 64-bit words and drives that row's psum memory write port.
module psum_pack_lane
    import psum_writer_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_clear,
    input  logic                  i_run,
    input  logic                  i_flush,
    input  logic [31:0]           i_base,
    input  logic [31:0]           i_num,
    input  logic                  i_valid,
    input  logic [PSUM_W-1:0]     i_data,
    output logic                  o_complete,
    output logic                  o_overflow,
    output logic [7:0]            o_we,
    output logic [31:0]           o_addr,
    output logic [2*PSUM_W-1:0]   o_din
);

    logic                r_half;
    logic [PSUM_W-1:0]   r_low;
    logic [31:0]         r_count;
    logic [31:0]         r_word_idx;
    logic [7:0]          r_we;
    logic [31:0]         r_addr;
    logic [2*PSUM_W-1:0] r_din;

    logic        w_below;
    logic        w_accept;
    logic [31:0] w_addr;

    assign w_below    = (r_count < i_num);
    assign w_accept   = i_run && i_valid && w_below;
    // Address arithmetic wraps modulo 2^32 on purpose.
    assign w_addr     = i_base + r_word_idx;
    assign o_complete = (r_count == i_num);
    // A valid past this row's quota while the tile is live is an overflow.
    assign o_overflow = i_valid && (i_run || i_flush) && !w_below;

    // Pack accepted psums into words, and emit a half word on flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_half     <= 1'b0;
            r_low      <= '0;
            r_count    <= '0;
            r_word_idx <= '0;
            r_we       <= '0;
            r_addr     <= '0;
            r_din      <= '0;
        end else begin
            // NOTE: non-blocking assignments, so every branch below reads the
            // pre-edge register values regardless of statement order.
            // NOTE: we returns to 0 every cycle, making each write a one-cycle
            // pulse; addr/din are left holding their last values.
            r_we <= '0;
            if (i_clear) begin
                r_half     <= 1'b0;
                r_count    <= '0;
                r_word_idx <= '0;
            end else if (w_accept) begin
                r_count <= r_count + 32'd1;
                if (!r_half) begin
                    r_low  <= i_data;
                    r_half <= 1'b1;
                end else begin
                    r_we       <= BE_FULL;
                    r_addr     <= w_addr;
                    r_din      <= {i_data, r_low};
                    r_word_idx <= r_word_idx + 32'd1;
                    r_half     <= 1'b0;
                end
            end else if (i_flush && r_half) begin
                r_we   <= BE_LO;
                r_addr <= w_addr;
                r_din  <= {{PSUM_W{1'b0}}, r_low};
                r_half <= 1'b0;
            end
        end
    end

    assign o_we   = r_we;
    assign o_addr = r_addr;
    assign o_din  = r_din;

endmodule

// File: rtl/psum_writer.sv
// Write-back stage from the PE array rows to the per-row psum memories:
// tile sequencing FSM plus one independent packing lane per row.
module psum_writer #(
    parameter int ROWS   = 3,
    parameter int PSUM_W = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [31:0]                   base_addr,
    input  logic [31:0]                   num_psums,
    input  logic [0:ROWS-1]               psum_valid,
    input  logic [0:ROWS-1][PSUM_W-1:0]   psum_data,
    output logic [0:ROWS-1][7:0]          psum_mem_we,
    output logic [0:ROWS-1][31:0]         psum_mem_addr,
    output logic [0:ROWS-1][2*PSUM_W-1:0] psum_mem_din,
    output logic                          busy,
    output logic                          done,
    output logic                          overflow
);

    import psum_writer_pkg::*;

    pw_state_t   r_state;
    logic [31:0] r_base;
    logic [31:0] r_num;
    logic        r_busy;
    logic        r_done;
    logic        r_overflow;

    logic            w_start_ok;
    logic            w_run;
    logic            w_flush;
    logic [ROWS-1:0] w_complete;
    logic [ROWS-1:0] w_lane_ovf;

    // A start is only honoured in IDLE; otherwise the inputs are not resampled.
    assign w_start_ok = start && (r_state == IDLE);
    assign w_run      = (r_state == RUN);
    assign w_flush    = (r_state == FLUSH);

    // Tile sequencing with registered busy/done/overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_base     <= '0;
            r_num      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_done <= (r_state == DONE);
            case (r_state)
                IDLE: begin
                    if (w_start_ok) begin
                        r_base     <= base_addr;
                        r_num      <= num_psums;
                        r_busy     <= 1'b1;
                        r_overflow <= 1'b0;
                        r_state    <= (num_psums == 32'd0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    // Rows may finish at different times; wait for all of them.
                    if (&w_complete) begin
                        r_state <= FLUSH;
                    end
                end
                FLUSH: begin
                    r_state <= DONE;
                end
                DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
            // Lanes only report overflow in RUN/FLUSH, so this never races the
            // clear on an accepted start.
            if (|w_lane_ovf) begin
                r_overflow <= 1'b1;
            end
        end
    end

    for (genvar g = 0; g < ROWS; g++) begin : g_lane
        psum_pack_lane u_lane (
            .clk        (clk),
            .rst_n      (rst_n),
            .i_clear    (w_start_ok),
            .i_run      (w_run),
            .i_flush    (w_flush),
            .i_base     (r_base),
            .i_num      (r_num),
            .i_valid    (psum_valid[g]),
            .i_data     (psum_data[g]),
            .o_complete (w_complete[g]),
            .o_overflow (w_lane_ovf[g]),
            .o_we       (psum_mem_we[g]),
            .o_addr     (psum_mem_addr[g]),
            .o_din      (psum_mem_din[g])
        );
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign overflow = r_overflow;

endmodule

// File: tb/tb_psum_writer.sv
// Scoreboard bench for psum_writer: a per-row model predicts every memory
// write (address, data, byte enables, cycle) plus done timing and overflow.
module tb_psum_writer;

    localparam int ROWS = 3;

    logic                   clk;
    logic                   rst_n;
    logic                   start;
    logic [31:0]            base_addr;
    logic [31:0]            num_psums;
    logic [0:ROWS-1]        psum_valid;
    logic [0:ROWS-1][31:0]  psum_data;
    logic [0:ROWS-1][7:0]   psum_mem_we;
    logic [0:ROWS-1][31:0]  psum_mem_addr;
    logic [0:ROWS-1][63:0]  psum_mem_din;
    logic                   busy;
    logic                   done;
    logic                   overflow;

    psum_writer #(.ROWS(ROWS), .PSUM_W(32)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .base_addr     (base_addr),
        .num_psums     (num_psums),
        .psum_valid    (psum_valid),
        .psum_data     (psum_data),
        .psum_mem_we   (psum_mem_we),
        .psum_mem_addr (psum_mem_addr),
        .psum_mem_din  (psum_mem_din),
        .busy          (busy),
        .done          (done),
        .overflow      (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Scoreboard of expected writes, one queue per row.
    typedef struct {
        logic [31:0] addr;
        logic [63:0] din;
        logic [7:0]  we;
        int          cyc;
    } wr_t;

    wr_t exp_q [ROWS][$];
    wr_t mon_e;

    // Reference model state.
    logic        m_active;
    logic [31:0] m_base;
    logic [31:0] m_num;
    logic        m_ovf;
    logic        m_half  [ROWS];
    logic [31:0] m_low   [ROWS];
    logic [31:0] m_count [ROWS];
    logic [31:0] m_idx   [ROWS];
    int          k_last;
    bit          any_acc;

    // Per-row stimulus schedule.
    int cfg_delay [ROWS];
    int cfg_gap   [ROWS];
    int cfg_extra [ROWS];

    task automatic cfg_default();
        for (int r = 0; r < ROWS; r++) begin
            cfg_delay[r] = 0;
            cfg_gap[r]   = 0;
            cfg_extra[r] = 0;
        end
    endtask

    task automatic model_start(input logic [31:0] base, input logic [31:0] num);
        m_active = 1'b1;
        m_base   = base;
        m_num    = num;
        m_ovf    = 1'b0;
        k_last   = 0;
        any_acc  = 1'b0;
        for (int r = 0; r < ROWS; r++) begin
            m_half[r]  = 1'b0;
            m_low[r]   = '0;
            m_count[r] = '0;
            m_idx[r]   = '0;
        end
    endtask

    // Valids driven in cycle k are accepted at the next edge; a completed
    // pair shows up on the memory port in cycle k+1.
    task automatic model_valid(input logic [0:ROWS-1] v, input logic [0:ROWS-1][31:0] d, input int k);
        wr_t e;
        for (int r = 0; r < ROWS; r++) begin
            if (v[r] && m_active) begin
                if (m_count[r] < m_num) begin
                    if (!m_half[r]) begin
                        m_low[r]  = d[r];
                        m_half[r] = 1'b1;
                    end else begin
                        e.addr = m_base + m_idx[r];
                        e.din  = {d[r], m_low[r]};
                        e.we   = 8'hFF;
                        e.cyc  = k + 1;
                        exp_q[r].push_back(e);
                        m_idx[r]  = m_idx[r] + 1;
                        m_half[r] = 1'b0;
                    end
                    m_count[r] = m_count[r] + 1;
                    k_last  = k;
                    any_acc = 1'b1;
                end else begin
                    m_ovf = 1'b1;
                end
            end
        end
    endtask

    // Last accept in cycle k: counts complete in k+1, FLUSH in k+2,
    // flush write visible in k+3, done in k+4.
    task automatic model_finish();
        wr_t e;
        for (int r = 0; r < ROWS; r++) begin
            if (m_half[r]) begin
                e.addr = m_base + m_idx[r];
                e.din  = {32'h0, m_low[r]};
                e.we   = 8'h0F;
                e.cyc  = k_last + 3;
                exp_q[r].push_back(e);
                m_half[r] = 1'b0;
            end
        end
        m_active = 1'b0;
    endtask

    // Output monitor: every write must match the head of its row's queue.
    always @(negedge clk) begin
        for (int r = 0; r < ROWS; r++) begin
            if (psum_mem_we[r] != 8'h00) begin
                if (exp_q[r].size() == 0) begin
                    check($sformatf("r%0d_unexpected_we", r), psum_mem_we[r], 64'h0);
                end else begin
                    mon_e = exp_q[r].pop_front();
                    check($sformatf("r%0d_addr", r), psum_mem_addr[r], mon_e.addr);
                    check($sformatf("r%0d_din", r),  psum_mem_din[r],  mon_e.din);
                    check($sformatf("r%0d_we", r),   psum_mem_we[r],   mon_e.we);
                    check($sformatf("r%0d_cycle", r), cyc, mon_e.cyc);
                end
            end
        end
    end

    task automatic check_outputs_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_ovf"}, overflow, 0);
        for (int r = 0; r < ROWS; r++) begin
            check($sformatf("%s_r%0d_we", tag, r),   psum_mem_we[r], 0);
            check($sformatf("%s_r%0d_addr", tag, r), psum_mem_addr[r], 0);
            check($sformatf("%s_r%0d_din", tag, r),  psum_mem_din[r], 0);
        end
    endtask

    task automatic run_tile(input logic [31:0] base, input logic [31:0] num, input bit inject_start);
        int              sent [ROWS];
        int              s;
        int              t;
        int              exp_done;
        bit              pend;
        bit              seen;
        logic [0:ROWS-1] v;
        logic [0:ROWS-1][31:0] d;

        @(negedge clk);
        start      = 1'b1;
        base_addr  = base;
        num_psums  = num;
        psum_valid = '0;
        s = cyc;
        model_start(base, num);
        for (int r = 0; r < ROWS; r++) sent[r] = 0;

        t    = 0;
        pend = 1'b1;
        while (t == 0 || pend) begin
            @(negedge clk);
            if (t == 0) begin
                check("busy_rise", busy, 1);
                check("ovf_clear_on_start", overflow, 0);
            end
            // A start while busy must be ignored, including its inputs.
            start     = inject_start && (t == 2);
            base_addr = start ? 32'hDEAD_0000 : base;
            num_psums = start ? 32'd7 : num;
            pend = 1'b0;
            for (int r = 0; r < ROWS; r++) begin
                v[r] = (sent[r] < int'(num) + cfg_extra[r]) && (t >= cfg_delay[r]) &&
                       (((t - cfg_delay[r]) % (cfg_gap[r] + 1)) == 0);
                d[r] = $urandom;
                if (v[r]) sent[r]++;
                if (sent[r] < int'(num) + cfg_extra[r]) pend = 1'b1;
            end
            psum_valid = v;
            psum_data  = d;
            model_valid(v, d, cyc);
            t++;
        end
        model_finish();
        exp_done = any_acc ? (k_last + 4) : (s + 2);

        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            psum_valid = '0;
            start      = 1'b0;
            if (done) begin
                seen = 1'b1;
                check("done_cycle", cyc, exp_done);
                check("busy_fall", busy, 0);
                break;
            end
            if (i == 0 && !inject_start) check("busy_held", busy, 1);
        end
        check("done_seen", seen, 1);
        @(negedge clk);
        check("done_one_pulse", done, 0);
        check("ovf_flag", overflow, m_ovf);
        for (int r = 0; r < ROWS; r++) begin
            check($sformatf("r%0d_queue_drained", r), exp_q[r].size(), 0);
        end
    endtask

    // Valids outside a tile are dropped and do not touch overflow.
    task automatic idle_valids(input int n, input logic exp_ovf);
        repeat (n) begin
            @(negedge clk);
            psum_valid = '1;
            for (int r = 0; r < ROWS; r++) psum_data[r] = $urandom;
        end
        @(negedge clk);
        psum_valid = '0;
        @(negedge clk);
        check("idle_valid_ovf", overflow, exp_ovf);
    endtask

    task automatic reset_mid_tile();
        logic [0:ROWS-1][31:0] d;
        @(negedge clk);
        start     = 1'b1;
        base_addr = 32'h200;
        num_psums = 32'd4;
        model_start(32'h200, 32'd4);
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            start = 1'b0;
            for (int r = 0; r < ROWS; r++) d[r] = $urandom;
            psum_valid = '1;
            psum_data  = d;
            model_valid('1, d, cyc);
        end
        // Third psum is now pending as a half word in every lane.
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_outputs_zero("mid_reset");
        for (int r = 0; r < ROWS; r++) exp_q[r].delete();
        m_active = 1'b0;
        @(negedge clk);
        psum_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_outputs_zero("after_reset");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        base_addr  = '0;
        num_psums  = '0;
        psum_valid = '0;
        psum_data  = '0;
        m_active   = 1'b0;
        cfg_default();
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Even count, back-to-back on all rows: two full words per row.
        run_tile(32'h100, 32'd4, 1'b0);
        // Odd count: one full word then a half-word flush.
        run_tile(32'h100, 32'd3, 1'b0);
        // Row 2 starts late with gapped valids; rows 0/1 must sit idle.
        cfg_delay[2] = 10;
        cfg_gap[2]   = 2;
        run_tile(32'h40, 32'd5, 1'b0);
        // Overflow: row 1 sends one psum too many.
        cfg_default();
        cfg_extra[1] = 1;
        run_tile(32'h100, 32'd2, 1'b0);
        idle_valids(2, 1'b1);
        // Zero-length tile: done two cycles after start, no writes.
        cfg_default();
        run_tile(32'h500, 32'd0, 1'b0);
        idle_valids(2, 1'b0);
        // Address wrap plus a start pulse while busy.
        run_tile(32'hFFFF_FFFF, 32'd4, 1'b1);
        // Random gaps on every row.
        for (int r = 0; r < ROWS; r++) cfg_gap[r] = $urandom_range(0, 3);
        run_tile(32'h7000_0000, 32'd7, 1'b0);
        // Reset mid-tile, then a fresh tile must not see stale half words.
        cfg_default();
        reset_mid_tile();
        run_tile(32'h300, 32'd2, 1'b0);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
